dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
// - Shares the single-port data memory (MemRead/MemWrite, 9-bit word address, 32-bit data) between
//   two requesters: port 0 = CPU load/store path, port 1 = DMA/debug loader.
// - Round-robin arbitration; optional bus lock for atomic multi-access sequences, bounded by a timeout.
// - Sits between the requesters and the data memory. Read data is registered, with 1-cycle latency.
// PARAMETERS
// - DM_ADDRESS   9    memory word-address width
// - DATA_W       32   data width
// - LOCK_MAX     16   max consecutive granted cycles while locked, before lock is forcibly dropped
// PORTS
// - clk          in   1           system clock, rising edge
// - rst_n        in   1           asynchronous, active-low reset
// - req[1:0]     in   2           access request per port
// - we[1:0]      in   2           1 = write, 0 = read (per port)
// - lock[1:0]    in   2           owner keeps the grant while req & lock are both high
// - addr0/addr1  in   DM_ADDRESS  word address per port
// - wdata0/1     in   DATA_W      write data per port
// - gnt[1:0]     out  2           one-hot or zero; access issued to memory this cycle
// - rvalid[1:0]  out  2           read data valid for the port granted a read in the previous cycle
// - rdata        out  DATA_W      registered read data, shared by both ports
// - mem_read     out  1           to MemRead
// - mem_write    out  1           to MemWrite
// - mem_a        out  DM_ADDRESS  to memory address
// - mem_wd       out  DATA_W      to memory write data
// - mem_rd       in   DATA_W      from memory combinational read data
// BEHAVIOUR
// - Reset (async, rst_n=0): rvalid=0, rdata=0, rr_ptr=0 (port 0 favoured), state=ARB, lock_cnt=0.
//   - gnt, mem_read and mem_write are forced to 0 combinationally while rst_n=0, so no write occurs.
//   - Memory contents are not touched by reset.
// - Handshake:
//   - A requester holds req/we/addr/wdata stable until it sees gnt high.
//   - gnt is combinational, in the same cycle. The access completes at that cycle's rising edge.
//   - A port may keep req high for back-to-back accesses.
// - Read latency: gnt read in cycle N -> rdata=mem_rd captured at the end of N -> rvalid pulses high in N+1 only.
//   - rdata holds its value until the next granted read.
// - Write: mem_write=1 only in the gnt cycle. No rvalid is produced.
// - Mux: mem_a/mem_wd/mem_read/mem_write come from the granted port; all are 0 when nothing is granted.
//   - mem_read = gnt & ~we; mem_write = gnt & we.
// - State ARB:
//   - If only one port requests, that port is granted.
//   - If both request, grant port rr_ptr; then rr_ptr <= ~granted port.
//   - If the granted port also has lock=1: next state LOCKED(owner), lock_cnt <= 1.
// - State LOCKED(owner):
//   - Owner req=1: grant the owner regardless of the other port; lock_cnt++.
//   - Exit to ARB when any of: owner lock=0, owner req=0 (no grant that cycle), or lock_cnt==LOCK_MAX.
//   - On timeout the final grant is still given; rr_ptr <= other port, so it wins next.
//   - The other port waits with no starvation beyond LOCK_MAX+1 cycles.
// - Simultaneous events:
//   - A lock request at the same time as contention: the RR winner takes the lock.
//   - rvalid for the previous read and a new gnt can be high in the same cycle (full pipelining).
// - Idle, req=0: gnt=0, no memory strobes, state stays ARB, rr_ptr unchanged.
// - Reset mid-lock: returns to ARB; a read in flight loses its rvalid. Requesters must reissue.
// STRUCTURE
// - Package dmem_pkg holds:
//   - typedef enum logic {ARB, LOCKED} arb_state_t
//   - localparams DM_ADDRESS/DATA_W defaults
//   - typedef struct {we, addr, wdata} dmem_req_t
// - One sub-module, rr_arb2: 2-way round-robin picker (req[1:0], rr_ptr -> gnt one-hot).
// - The lock FSM, counter, command mux and read-data register live in the top module.
// TESTING
// - Single read: port0 req, addr=0x005 (mem=0xDEADBEEF) -> gnt0 same cycle, rvalid0 next cycle, rdata=0xDEADBEEF.
// - Contention: both req continuously after reset -> grants alternate 0,1,0,1. Writes land at the correct addresses.
// - Lock: port1 req+lock for 4 cycles, port0 req held -> gnt1 x4, then gnt0. Port1 writes are contiguous.
// - Timeout: port1 lock held forever, LOCK_MAX=16 -> gnt1 x16, then gnt0 on cycle 17, and no starvation thereafter.
// - Write-then-read: port0 write 0x1234_5678 @0x1FF, then read @0x1FF -> rdata=0x12345678 (address wrap-top boundary).
// - Reset mid-lock: assert rst_n=0 during LOCKED with a read issued -> gnt/mem_write=0 immediately,
//   rvalid=0, memory unchanged, port0 favoured after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Imported by the interface, the round-robin picker and the top.
package dmem_pkg;

   localparam int DM_ADDRESS = 9;
   localparam int DATA_W     = 32;
   localparam int LOCK_MAX   = 16;

   typedef enum logic {
      ARB,
      LOCKED
   } arb_state_t;

   typedef struct packed {
      logic                  we;
      logic [DM_ADDRESS-1:0] addr;
      logic [DATA_W-1:0]     wdata;
   } dmem_req_t;

endpackage

// File: rtl/dmem_if.sv
// Requester and memory-side signals of the data-memory arbiter.
// master = requesters + memory, slave = arbiter.
interface dmem_if #(
   parameter int AW = dmem_pkg::DM_ADDRESS,
   parameter int DW = dmem_pkg::DATA_W
);
   logic [1:0]    req;
   logic [1:0]    we;
   logic [1:0]    lock;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic [1:0]    gnt;
   logic [1:0]    rvalid;
   logic [DW-1:0] rdata;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd;

   modport master (
      output req, we, lock, addr0, addr1, wdata0, wdata1, mem_rd,
      input  gnt, rvalid, rdata, mem_read, mem_write, mem_a, mem_wd
   );

   modport slave (
      input  req, we, lock, addr0, addr1, wdata0, wdata1, mem_rd,
      output gnt, rvalid, rdata, mem_read, mem_write, mem_a, mem_wd
   );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins,
// on contention rr_ptr names the winner.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       rr_ptr,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      unique case (1'b1)
         (req == 2'b11): gnt = rr_ptr ? 2'b10 : 2'b01;
         (req == 2'b01): gnt = 2'b01;
         (req == 2'b10): gnt = 2'b10;
         default:        gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with timed bus lock in front of the
// single-port data memory; read data is registered.
module dmem_arbiter #(
   parameter int DM_ADDRESS = dmem_pkg::DM_ADDRESS,
   parameter int DATA_W     = dmem_pkg::DATA_W,
   parameter int LOCK_MAX   = dmem_pkg::LOCK_MAX
) (
   input logic   clk,
   input logic   rst_n,
   dmem_if.slave bus
);
   import dmem_pkg::*;

   localparam int CW = $clog2(LOCK_MAX + 1);

   arb_state_t        state_q, state_d;
   logic              owner_q, owner_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]     lock_cnt_q, lock_cnt_d;
   logic [CW-1:0]     cnt_inc;
   logic [1:0]        rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [1:0] rr_gnt;
   logic [1:0] gnt;
   logic       any_g;
   logic       rd_go;
   logic       wr_go;
   dmem_req_t  rq0, rq1, sel;

   rr_arb2 u_rr (
      .req    (bus.req),
      .rr_ptr (rr_ptr_q),
      .gnt    (rr_gnt)
   );

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      lock_cnt_d = lock_cnt_q;
      gnt        = 2'b00;
      cnt_inc    = lock_cnt_q + 1'b1;
      unique case (state_q)
         ARB: begin
            gnt = rr_gnt;
            if (|rr_gnt) begin
               if (&bus.req) rr_ptr_d = ~rr_gnt[1];
               if (bus.lock[rr_gnt[1]]) begin
                  state_d    = LOCKED;
                  owner_d    = rr_gnt[1];
                  lock_cnt_d = CW'(1);
               end
            end
         end
         LOCKED: begin
            if (bus.req[owner_q]) begin
               gnt[owner_q] = 1'b1;
               lock_cnt_d   = cnt_inc;
               // timeout: last grant still given, other port wins next
               if (cnt_inc == CW'(LOCK_MAX)) begin
                  state_d    = ARB;
                  rr_ptr_d   = ~owner_q;
                  lock_cnt_d = '0;
               end else if (!bus.lock[owner_q]) begin
                  state_d    = ARB;
                  lock_cnt_d = '0;
               end
            end else begin
               state_d    = ARB;
               lock_cnt_d = '0;
            end
         end
         default: state_d = ARB;
      endcase
      if (!rst_n) gnt = 2'b00;
   end

   always_comb begin
      rq0   = '{we: bus.we[0], addr: bus.addr0, wdata: bus.wdata0};
      rq1   = '{we: bus.we[1], addr: bus.addr1, wdata: bus.wdata1};
      sel   = gnt[1] ? rq1 : rq0;
      any_g = |gnt;
      rd_go = any_g & ~sel.we;
      wr_go = any_g & sel.we;
   end

   always_comb begin
      rvalid_d = gnt & ~bus.we;
      rdata_d  = rd_go ? bus.mem_rd : rdata_q;
   end

   assign bus.gnt       = gnt;
   assign bus.mem_read  = rd_go;
   assign bus.mem_write = wr_go;
   assign bus.mem_a     = any_g ? sel.addr : '0;
   assign bus.mem_wd    = any_g ? sel.wdata : '0;
   assign bus.rvalid    = rvalid_q;
   assign bus.rdata     = rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB;
         owner_q    <= 1'b0;
         rr_ptr_q   <= 1'b0;
         lock_cnt_q <= '0;
         rvalid_q   <= 2'b00;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_cnt_q <= lock_cnt_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
      end
   end

endmodule
